// File: rtl/io_bridge_ic_pkg.sv
// rtl/io_bridge_ic_pkg.sv - shared constants and types for the io_bridge_ic peripheral bridge
package io_bridge_ic_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_7F00;
    localparam int          DEFAULT_SPAN_LOG2 = 4;
    localparam int          HWINT_W           = 6;
    localparam int          IC_SPAN           = 16;

    // Interrupt controller register select: byte offset within the IC window divided by 4
    // (IMR=0x0, IPR=0x4, MODE=0x8, ERRADDR=0xC).
    typedef enum logic [1:0] {
        IC_IMR     = 2'd0,
        IC_IPR     = 2'd1,
        IC_MODE    = 2'd2,
        IC_ERRADDR = 2'd3
    } ic_reg_e;

endpackage

// File: rtl/io_bridge_ic_irq_ctrl.sv
// rtl/io_bridge_ic_irq_ctrl.sv - mask/pending/mode interrupt controller feeding HWInt
module io_bridge_ic_irq_ctrl
    import io_bridge_ic_pkg::*;
#(
    parameter int NUM_DEV = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en_i,
    input  ic_reg_e            wr_sel_i,
    input  logic [NUM_DEV-1:0] wr_data_i,
    input  logic [NUM_DEV-1:0] dev_irq_i,
    output logic [NUM_DEV-1:0] imr_o,
    output logic [NUM_DEV-1:0] ipr_o,
    output logic [NUM_DEV-1:0] mode_o,
    output logic [HWINT_W-1:0] hwint_o
);

    logic [NUM_DEV-1:0] imr_q, imr_d;
    logic [NUM_DEV-1:0] ipr_q, ipr_d;
    logic [NUM_DEV-1:0] mode_q, mode_d;
    logic [NUM_DEV-1:0] irq_prev_q;
    logic [NUM_DEV-1:0] rise;
    logic [NUM_DEV-1:0] w1c;

    // Next-state for mask, mode and pending; the current MODE governs this cycle, so a MODE write lands next cycle.
    always_comb begin
        rise   = dev_irq_i & ~irq_prev_q;
        w1c    = (wr_en_i && wr_sel_i == IC_IPR) ? wr_data_i : '0;
        imr_d  = (wr_en_i && wr_sel_i == IC_IMR) ? wr_data_i : imr_q;
        mode_d = (wr_en_i && wr_sel_i == IC_MODE) ? wr_data_i : mode_q;
        // Edge sources: a new edge beats a simultaneous W1C. Level sources follow the line.
        ipr_d  = (mode_q & (rise | (ipr_q & ~w1c))) | (~mode_q & dev_irq_i);
    end

    // State registers; prev starts at 0 so a line already high after reset counts as an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            imr_q      <= '1;
            ipr_q      <= '0;
            mode_q     <= '0;
            irq_prev_q <= '0;
        end else begin
            imr_q      <= imr_d;
            ipr_q      <= ipr_d;
            mode_q     <= mode_d;
            irq_prev_q <= dev_irq_i;
        end
    end

    assign imr_o   = imr_q;
    assign ipr_o   = ipr_q;
    assign mode_o  = mode_q;
    assign hwint_o = HWINT_W'(ipr_q & imr_q);

endmodule

// File: rtl/io_bridge_ic.sv
// rtl/io_bridge_ic.sv - peripheral address decode, write gating, read mux and interrupt controller
module io_bridge_ic
    import io_bridge_ic_pkg::*;
#(
    parameter int          NUM_DEV   = 2,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          SPAN_LOG2 = DEFAULT_SPAN_LOG2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            pr_addr,
    input  logic [31:0]            pr_wd,
    input  logic                   pr_we,
    input  logic                   int_req,
    output logic [31:0]            pr_rd,
    output logic                   pr_err,
    output logic [29:0]            dev_addr,
    output logic [31:0]            dev_wd,
    output logic [NUM_DEV-1:0]     dev_we,
    input  logic [32*NUM_DEV-1:0]  dev_rd,
    input  logic [NUM_DEV-1:0]     dev_irq,
    output logic [HWINT_W-1:0]     HWInt
);

    localparam logic [31:0] DEV_SPAN = 32'(NUM_DEV) << SPAN_LOG2;

    logic [31:0]        offset;
    logic               in_range;
    logic [NUM_DEV-1:0] dev_hit;
    logic               ic_hit;
    ic_reg_e            ic_sel;
    logic               wr_ok;
    logic               ic_wr;
    logic [NUM_DEV-1:0] imr, ipr, mode;
    logic [31:0]        erraddr_q, erraddr_d;

    // Address decode: device windows first, then the 16-byte IC window right after them.
    always_comb begin
        offset   = pr_addr - BASE_ADDR;
        in_range = (pr_addr >= BASE_ADDR);
        for (int k = 0; k < NUM_DEV; k++) begin
            dev_hit[k] = in_range && ((offset >> SPAN_LOG2) == 32'(k));
        end
        ic_hit = in_range && (offset >= DEV_SPAN) && (offset < DEV_SPAN + 32'(IC_SPAN));
        ic_sel = ic_reg_e'(2'((offset - DEV_SPAN) >> 2));
    end

    assign wr_ok    = pr_we & ~int_req;
    assign ic_wr    = wr_ok & ic_hit;
    assign pr_err   = ~(|dev_hit | ic_hit);
    assign dev_we   = wr_ok ? dev_hit : '0;
    assign dev_addr = pr_addr[31:2];
    assign dev_wd   = pr_wd;

    // Zero-latency read mux; unmapped reads return 0.
    always_comb begin
        pr_rd = 32'h0;
        for (int k = 0; k < NUM_DEV; k++) begin
            if (dev_hit[k]) pr_rd = dev_rd[32*k +: 32];
        end
        if (ic_hit) begin
            case (ic_sel)
                IC_IMR:     pr_rd = 32'(imr);
                IC_IPR:     pr_rd = 32'(ipr);
                IC_MODE:    pr_rd = 32'(mode);
                IC_ERRADDR: pr_rd = erraddr_q;
                default:    pr_rd = 32'h0;
            endcase
        end
    end

    // ERRADDR capture: bit 0 doubles as a sticky valid flag since stores are word aligned.
    always_comb begin
        erraddr_d = erraddr_q;
        if (wr_ok && pr_err) begin
            erraddr_d = {pr_addr[31:1], 1'b1};
        end else if (ic_wr && ic_sel == IC_ERRADDR) begin
            erraddr_d = 32'h0;
        end
    end

    // ERRADDR register.
    always_ff @(posedge clk) begin
        if (!reset) erraddr_q <= 32'h0;
        else        erraddr_q <= erraddr_d;
    end

    io_bridge_ic_irq_ctrl #(
        .NUM_DEV (NUM_DEV)
    ) u_irq_ctrl (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (ic_wr),
        .wr_sel_i  (ic_sel),
        .wr_data_i (pr_wd[NUM_DEV-1:0]),
        .dev_irq_i (dev_irq),
        .imr_o     (imr),
        .ipr_o     (ipr),
        .mode_o    (mode),
        .hwint_o   (HWInt)
    );

endmodule

// File: tb/tb_io_bridge_ic.sv
// tb/tb_io_bridge_ic.sv - self-checking bench for io_bridge_ic
module tb_io_bridge_ic;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pr_addr, pr_wd;
    logic        pr_we, int_req;
    logic [31:0] pr_rd, pr_rd1, pr_rd6;
    logic        pr_err, pr_err1, pr_err6;
    logic [29:0] dev_addr, dev_addr1, dev_addr6;
    logic [31:0] dev_wd, dev_wd1, dev_wd6;
    logic [2:0]  dev_we;
    logic [0:0]  dev_we1;
    logic [5:0]  dev_we6;
    logic [95:0] dev_rd;
    logic [31:0] dev_rd1;
    logic [191:0] dev_rd6;
    logic [2:0]  dev_irq;
    logic [0:0]  dev_irq1;
    logic [5:0]  dev_irq6;
    logic [5:0]  hw, hw1, hw6;

    always #5 clk = ~clk;

    io_bridge_ic #(.NUM_DEV(3)) dut (
        .clk(clk), .reset(reset), .pr_addr(pr_addr), .pr_wd(pr_wd), .pr_we(pr_we), .int_req(int_req),
        .pr_rd(pr_rd), .pr_err(pr_err), .dev_addr(dev_addr), .dev_wd(dev_wd), .dev_we(dev_we),
        .dev_rd(dev_rd), .dev_irq(dev_irq), .HWInt(hw));

    io_bridge_ic #(.NUM_DEV(1)) dut1 (
        .clk(clk), .reset(reset), .pr_addr(pr_addr), .pr_wd(pr_wd), .pr_we(pr_we), .int_req(int_req),
        .pr_rd(pr_rd1), .pr_err(pr_err1), .dev_addr(dev_addr1), .dev_wd(dev_wd1), .dev_we(dev_we1),
        .dev_rd(dev_rd1), .dev_irq(dev_irq1), .HWInt(hw1));

    io_bridge_ic #(.NUM_DEV(6)) dut6 (
        .clk(clk), .reset(reset), .pr_addr(pr_addr), .pr_wd(pr_wd), .pr_we(pr_we), .int_req(int_req),
        .pr_rd(pr_rd6), .pr_err(pr_err6), .dev_addr(dev_addr6), .dev_wd(dev_wd6), .dev_we(dev_we6),
        .dev_rd(dev_rd6), .dev_irq(dev_irq6), .HWInt(hw6));

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state for the NUM_DEV=3 instance.
    logic [2:0]  m_imr, m_ipr, m_mode, m_prev;
    logic [31:0] m_err;
    bit          m_valid = 0;

    logic [31:0] obs_rd, obs_rd1, obs_rd6;
    logic [5:0]  obs_hw, obs_hw1;
    logic [2:0]  obs_we;
    logic        obs_err, obs_err1, obs_err6;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Which window an address falls into: device index or IC register index, -1 when not.
    function automatic void decode(input logic [31:0] a, output int dev, output int icr);
        dev = -1;
        icr = -1;
        if (a >= BASE && a < BASE + 32'd48)               dev = int'((a - BASE) / 16);
        else if (a >= BASE + 32'd48 && a < BASE + 32'd64) icr = int'((a - BASE - 32'd48) / 4);
    endfunction

    task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic ir,
                       input logic [2:0] irq, input logic rstn);
        int dev, icr;
        logic [31:0] e_rd;
        logic [2:0]  e_we;
        logic [2:0]  clr, nxt;
        @(negedge clk);
        pr_addr = a; pr_wd = wd; pr_we = we; int_req = ir; reset = rstn;
        dev_irq = irq; dev_irq1 = irq[0]; dev_irq6 = {3'b000, irq};
        dev_rd  = {$urandom, $urandom, $urandom};
        dev_rd1 = $urandom;
        dev_rd6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        #1;
        obs_rd = pr_rd; obs_err = pr_err; obs_we = dev_we; obs_hw = hw;
        obs_rd1 = pr_rd1; obs_err1 = pr_err1; obs_hw1 = hw1;
        obs_rd6 = pr_rd6; obs_err6 = pr_err6;
        decode(a, dev, icr);
        if (m_valid) begin
            e_rd = 32'h0;
            if (dev >= 0) e_rd = dev_rd[dev*32 +: 32];
            else if (icr == 0) e_rd = {29'h0, m_imr};
            else if (icr == 1) e_rd = {29'h0, m_ipr};
            else if (icr == 2) e_rd = {29'h0, m_mode};
            else if (icr == 3) e_rd = m_err;
            e_we = (dev >= 0 && we && !ir) ? 3'(1 << dev) : 3'b000;
            chk("pr_rd", obs_rd, e_rd);
            chk("pr_err", 32'(obs_err), 32'(dev < 0 && icr < 0));
            chk("dev_we", 32'(obs_we), 32'(e_we));
            chk("HWInt", 32'(obs_hw), 32'(m_ipr & m_imr));
            chk("dev_addr", 32'(dev_addr), 32'(a[31:2]));
            chk("dev_wd", dev_wd, wd);
            chk("hw1_upper", 32'(obs_hw1[5:1]), 32'h0);
        end
        @(posedge clk);
        if (!rstn) begin
            m_imr = 3'b111; m_ipr = 3'b000; m_mode = 3'b000; m_prev = 3'b000; m_err = 32'h0;
            m_valid = 1;
        end else begin
            clr = (we && !ir && icr == 1) ? wd[2:0] : 3'b000;
            for (int k = 0; k < 3; k++) begin
                if (m_mode[k]) nxt[k] = (irq[k] && !m_prev[k]) || (m_ipr[k] && !clr[k]);
                else           nxt[k] = irq[k];
            end
            if (we && !ir) begin
                if (icr == 0) m_imr  = wd[2:0];
                if (icr == 2) m_mode = wd[2:0];
                if (icr == 3) m_err  = 32'h0;
                if (dev < 0 && icr < 0) m_err = {a[31:1], 1'b1};
            end
            m_ipr  = nxt;
            m_prev = irq;
        end
    endtask

    initial begin
        // Reset and reset-state reads.
        cyc(32'h0, 32'h0, 0, 0, 3'b000, 0);
        cyc(32'h0, 32'h0, 0, 0, 3'b000, 0);
        cyc(32'h7F30, 32'h0, 0, 0, 3'b000, 1);
        chk("reset_imr", obs_rd, 32'h7);
        chk("reset_hw", 32'(obs_hw), 32'h0);
        cyc(32'h7F38, 32'h0, 0, 0, 3'b000, 1);
        chk("reset_mode", obs_rd, 32'h0);

        // Decode and write gating.
        cyc(32'h7F14, 32'hDEAD_BEEF, 1, 0, 3'b000, 1);
        chk("sw_dev1_we", 32'(obs_we), 32'h2);
        cyc(32'h7F14, 32'h0, 0, 0, 3'b000, 1);
        chk("sw_dev1_done", 32'(obs_we), 32'h0);
        cyc(32'h7F14, 32'h1234, 1, 1, 3'b000, 1);
        chk("sw_intreq_we", 32'(obs_we), 32'h0);
        cyc(32'h7F24, 32'h0, 0, 0, 3'b000, 1);
        chk("rd_dev2", obs_rd, dev_rd[95:64]);

        // Level interrupt and masking.
        cyc(32'h7F00, 32'h0, 0, 0, 3'b001, 1);
        cyc(32'h7F00, 32'h0, 0, 0, 3'b001, 1);
        chk("level_hw", 32'(obs_hw), 32'h1);
        cyc(32'h7F30, 32'h0, 1, 0, 3'b001, 1);
        cyc(32'h7F34, 32'h0, 0, 0, 3'b001, 1);
        chk("masked_hw", 32'(obs_hw), 32'h0);
        chk("masked_ipr", obs_rd, 32'h1);
        cyc(32'h7F00, 32'h0, 0, 0, 3'b000, 1);
        cyc(32'h7F34, 32'h0, 0, 0, 3'b000, 1);
        chk("level_fall", obs_rd, 32'h0);
        cyc(32'h7F30, 32'h7, 1, 0, 3'b000, 1);

        // Edge mode, W1C, set beats clear.
        cyc(32'h7F38, 32'h2, 1, 0, 3'b000, 1);
        cyc(32'h7F00, 32'h0, 0, 0, 3'b010, 1);
        cyc(32'h7F00, 32'h0, 0, 0, 3'b000, 1);
        cyc(32'h7F34, 32'h0, 0, 0, 3'b000, 1);
        chk("edge_latched", obs_rd, 32'h2);
        chk("edge_hw", 32'(obs_hw), 32'h2);
        cyc(32'h7F34, 32'h2, 1, 0, 3'b000, 1);
        cyc(32'h7F34, 32'h0, 0, 0, 3'b000, 1);
        chk("w1c_clear", obs_rd, 32'h0);
        cyc(32'h7F34, 32'h2, 1, 0, 3'b010, 1);
        cyc(32'h7F34, 32'h0, 0, 0, 3'b000, 1);
        chk("set_beats_clear", obs_rd, 32'h2);

        // Unmapped store and ERRADDR.
        cyc(32'h7F40, 32'hFFFF_FFFF, 1, 0, 3'b000, 1);
        chk("unmapped_err", 32'(obs_err), 32'h1);
        chk("unmapped_we", 32'(obs_we), 32'h0);
        cyc(32'h7F3C, 32'h0, 0, 0, 3'b000, 1);
        chk("erraddr", obs_rd, 32'h7F41);
        cyc(32'h7F3C, 32'h5555_5555, 1, 0, 3'b000, 1);
        cyc(32'h7F3C, 32'h0, 0, 0, 3'b000, 1);
        chk("erraddr_clr", obs_rd, 32'h0);

        // Reset mid-operation.
        cyc(32'h7F30, 32'h0, 1, 0, 3'b000, 1);
        cyc(32'h7F38, 32'h7, 1, 0, 3'b000, 1);
        cyc(32'h7F00, 32'h0, 0, 0, 3'b001, 1);
        cyc(32'h7F00, 32'h0, 0, 0, 3'b001, 0);
        cyc(32'h7F30, 32'h0, 0, 0, 3'b000, 1);
        chk("rst_imr", obs_rd, 32'h7);
        chk("rst_hw", 32'(obs_hw), 32'h0);
        cyc(32'h7F34, 32'h0, 0, 0, 3'b000, 1);
        chk("rst_ipr", obs_rd, 32'h0);
        cyc(32'h7F38, 32'h0, 0, 0, 3'b000, 1);
        chk("rst_mode", obs_rd, 32'h0);

        // Parameter sweep: IC window position for NUM_DEV=1 and 6.
        cyc(32'h7F10, 32'h0, 0, 0, 3'b000, 1);
        chk("n1_ic_imr", obs_rd1, 32'h1);
        chk("n1_ic_err", 32'(obs_err1), 32'h0);
        cyc(32'h7F20, 32'h0, 0, 0, 3'b000, 1);
        chk("n1_past_ic", 32'(obs_err1), 32'h1);
        cyc(32'h7F60, 32'h0, 0, 0, 3'b000, 1);
        chk("n6_ic_imr", obs_rd6, 32'h3F);
        cyc(32'h7F5C, 32'h0, 0, 0, 3'b000, 1);
        chk("n6_dev5_err", 32'(obs_err6), 32'h0);
        cyc(32'h7F70, 32'h0, 0, 0, 3'b001, 1);
        chk("n6_past_ic", 32'(obs_err6), 32'h1);
        cyc(32'h7F00, 32'h0, 0, 0, 3'b001, 1);
        chk("n1_hw", 32'(obs_hw1), 32'h1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 500; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else                           a = BASE + 32'(4 * $urandom_range(0, 19));
            cyc(a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                3'($urandom), $urandom_range(0, 49) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
